mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer.sv | 119 +++++++++++
 tb/tb_mem_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
`default_nettype none
// ==== mem_sequencer: fetch/load/store memory sequencer with CPU step enable ====
// Rev 1.0 - initial release
module mem_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] i_addr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] instr,
  output logic [31:0] read_data,
  output logic        step,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        fault,
  output logic [31:0] instr_count
);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FWAIT = 3'd2,
    S_DATA  = 3'd3,
    S_DWAIT = 3'd4,
    S_EXEC  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  state_t state, state_next;

  logic is_mem_op;
  logic is_store;

  // Memory-op decode in FWAIT looks at the word arriving now; in DATA it
  // looks at the word already latched into instr.
  assign is_mem_op = (mem_rdata[6:0] == OP_LOAD) || (mem_rdata[6:0] == OP_STORE);
  assign is_store  = (instr[6:0] == OP_STORE);
  assign busy      = (state != S_IDLE) && (state != S_HALT);

  always_comb begin
    state_next = state;
    step       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_addr[1:0] != 2'b00) begin
          state_next = S_HALT;
        end else begin
          mem_re     = 1'b1;
          mem_addr   = i_addr;
          state_next = S_FWAIT;
        end
      end
      S_FWAIT: begin
        state_next = is_mem_op ? S_DATA : S_EXEC;
      end
      S_DATA: begin
        if (d_addr[1:0] != 2'b00) begin
          state_next = S_HALT;
        end else if (is_store) begin
          mem_we     = 1'b1;
          mem_addr   = d_addr;
          mem_wdata  = d_wdata;
          state_next = S_EXEC;
        end else begin
          mem_re     = 1'b1;
          mem_addr   = d_addr;
          state_next = S_DWAIT;
        end
      end
      S_DWAIT: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        step       = 1'b1;
        state_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      instr       <= NOP_INSTR;
      read_data   <= 32'd0;
      instr_count <= 32'd0;
      fault       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FWAIT) instr <= mem_rdata;
      if (state == S_DWAIT) read_data <= mem_rdata;
      if (step) instr_count <= instr_count + 32'd1;
      if (state_next == S_HALT) fault <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ==== tb_mem_sequencer: randomized self-checking bench for mem_sequencer ====
// Rev 1.0 - initial release
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] instr, read_data, mem_addr, mem_wdata, instr_count;
  logic        step, mem_re, mem_we, busy, fault;

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .i_addr(i_addr), .d_addr(d_addr), .d_wdata(d_wdata),
    .instr(instr), .read_data(read_data), .step(step),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .fault(fault), .instr_count(instr_count)
  );

  typedef logic [164:0] snap_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural view: what the CPU should currently see.
  logic [31:0] m_instr, m_rd, m_count;

  function automatic snap_t mk(input logic st, re, we, input logic [31:0] a, wd,
                               input logic bz, ft, input logic [31:0] ins, rd, cnt);
    return {st, re, we, a, wd, bz, ft, ins, rd, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input snap_t exp);
    snap_t got;
    #1;
    got = {step, mem_re, mem_we, mem_addr, mem_wdata, busy, fault, instr, read_data, instr_count};
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_instr = 32'h0000_0033;
    m_rd    = 32'd0;
    m_count = 32'd0;
  endtask

  // cls: 0 = non-memory, 1 = load, 2 = store. Starts in the cycle before FETCH.
  task automatic do_instr(input int cls, input logic [31:0] word, ia, da, wd, ld,
                          input bit drop, input string tag);
    bit is_load, is_store, re, we;
    int lat;
    logic [31:0] a, w;
    is_load  = (cls == 1);
    is_store = (cls == 2);
    lat      = 3 + ((cls != 0) ? 1 : 0) + (is_load ? 1 : 0);
    i_addr   = ia;
    d_addr   = da;
    d_wdata  = wd;
    for (int k = 0; k < lat; k++) begin
      tick();
      if (k == 1)                 mem_rdata = word;
      else if (is_load && k == 3) mem_rdata = ld;
      else                        mem_rdata = $urandom;
      if (drop && k == 1) run = 1'b0;
      if (k == 2) m_instr = word;
      if (is_load && k == 4) m_rd = ld;
      re = (k == 0) || (is_load && k == 2);
      we = is_store && (k == 2);
      a  = (k == 0) ? ia : ((k == 2 && cls != 0) ? da : 32'd0);
      w  = we ? wd : 32'd0;
      check(tag, mk(k == lat - 1, re, we, a, w, 1'b1, 1'b0, m_instr, m_rd, m_count));
    end
    m_count++;
    if (drop) begin
      int extra;
      extra = $urandom_range(0, 2);
      tick();
      check({tag, "_idle"}, mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));
      for (int j = 0; j < extra; j++) begin
        tick();
        check({tag, "_idle"}, mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));
      end
      run = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] r, word, ia, da, wd, ld;
    logic [6:0]  op;
    int          cls;
    bit          drop;

    reset = 1'b1; run = 1'b0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    model_reset();
    tick();
    tick();
    check("reset", mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));
    reset = 1'b0;
    run   = 1'b1;

    do_instr(0, 32'h001080B3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, "add");
    do_instr(1, 32'h00002083, 32'h4, 32'h0, 32'h0, 32'h000000FF, 1'b0, "lw");
    do_instr(2, 32'h00102023, 32'h8, 32'h0, 32'h000001FE, 32'h0, 1'b0, "sw");
    do_instr(0, 32'h00208133, 32'hC, 32'h0, 32'h0, 32'h0, 1'b1, "run_drop");

    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 2);
      r   = $urandom;
      case (cls)
        1: op = 7'b0000011;
        2: op = 7'b0100011;
        default: begin
          op = r[6:0];
          if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0110011;
        end
      endcase
      word = {r[31:7], op};
      ia   = $urandom & 32'hFFFF_FFFC;
      da   = $urandom & 32'hFFFF_FFFC;
      wd   = $urandom;
      ld   = $urandom;
      drop = ($urandom_range(0, 3) == 0);
      do_instr(cls, word, ia, da, wd, ld, drop, "rand");
    end

    // Misaligned fetch, reset taking priority over an instruction in flight.
    reset = 1'b1;
    tick();
    model_reset();
    check("reset_busy", mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));
    reset = 1'b0; run = 1'b1; i_addr = 32'h2;
    tick();
    check("misfetch_fetch", mk(0, 0, 0, 0, 0, 1, 0, m_instr, m_rd, m_count));
    tick();
    check("misfetch_halt", mk(0, 0, 0, 0, 0, 0, 1, m_instr, m_rd, m_count));
    run = 1'b0;
    tick();
    check("halt_run0", mk(0, 0, 0, 0, 0, 0, 1, m_instr, m_rd, m_count));
    run = 1'b1;
    tick();
    check("halt_run1", mk(0, 0, 0, 0, 0, 0, 1, m_instr, m_rd, m_count));
    reset = 1'b1;
    tick();
    check("reset_clears_fault", mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));

    // Misaligned load data address.
    reset = 1'b0; run = 1'b1; i_addr = 32'h10; d_addr = 32'h1;
    tick();
    check("misload_fetch", mk(0, 1, 0, 32'h10, 0, 1, 0, m_instr, m_rd, m_count));
    tick();
    mem_rdata = 32'h00002083;
    check("misload_fwait", mk(0, 0, 0, 0, 0, 1, 0, m_instr, m_rd, m_count));
    tick();
    mem_rdata = $urandom;
    m_instr = 32'h00002083;
    check("misload_data", mk(0, 0, 0, 0, 0, 1, 0, m_instr, m_rd, m_count));
    tick();
    check("misload_halt", mk(0, 0, 0, 0, 0, 0, 1, m_instr, m_rd, m_count));
    reset = 1'b1;
    tick();
    model_reset();
    check("reset_after_misload", mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));

    // Reset asserted while a store is in DATA.
    reset = 1'b0; run = 1'b1;
    do_instr(0, 32'h00310233, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, "pre_store");
    i_addr = 32'h20; d_addr = 32'h40; wd = $urandom; d_wdata = wd;
    tick();
    check("rst_store_fetch", mk(0, 1, 0, 32'h20, 0, 1, 0, m_instr, m_rd, m_count));
    tick();
    mem_rdata = 32'h00102023;
    check("rst_store_fwait", mk(0, 0, 0, 0, 0, 1, 0, m_instr, m_rd, m_count));
    tick();
    mem_rdata = $urandom;
    m_instr = 32'h00102023;
    check("rst_store_data", mk(0, 0, 1, 32'h40, wd, 1, 0, m_instr, m_rd, m_count));
    reset = 1'b1;
    tick();
    model_reset();
    check("rst_store_after", mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));
    reset = 1'b0; run = 1'b0;
    tick();
    check("idle_after_reset", mk(0, 0, 0, 0, 0, 0, 0, m_instr, m_rd, m_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
